// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Registered front end for a small multi-function ALU. A request (opcode plus
// two operands) is taken through a valid/ready handshake, the operands are
// registered and the opcode is decoded into a one-hot enable vector for the
// function units. The units AND their results with their own enable, so their
// outputs merge on a wired-OR bus. The enable is held for SETTLE cycles, then
// the bus is captured and returned, with a zero flag, through a second
// valid/ready handshake. A sticky fault flags a non-zero bus while no unit is
// enabled.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  sequencer can accept a request (low while rst is high)
//   req_op     function select
//   req_a      operand A
//   req_b      operand B
//   a, b       registered operands to the function units
//   en         one-hot unit enable, all zero when not driving
//   unit_ans   OR of all unit outputs
//   rsp_valid  result available
//   rsp_ready  consumer accepts the result
//   rsp_ans    captured result
//   rsp_zero   captured result is zero
//   fault      sticky bus fault, cleared only by rst

module alu_op_sequencer #(
  parameter int WIDTH  = 4,
  parameter int NFUNC  = 16,
  parameter int SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(NFUNC)-1:0] req_op,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  output logic [WIDTH-1:0]         a,
  output logic [WIDTH-1:0]         b,
  output logic [NFUNC-1:0]         en,
  input  logic [WIDTH-1:0]         unit_ans,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_ans,
  output logic                     rsp_zero,
  output logic                     fault
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } seqState_t;

  // SETTLE is limited to 1..4, so two bits always hold SETTLE-1.
  localparam logic [1:0] CNT_LOAD = 2'(SETTLE - 1);

  seqState_t          r_state;
  seqState_t          w_stateNext;
  logic [1:0]         r_cnt;
  logic [1:0]         w_cntNext;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   w_aNext;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   w_bNext;
  logic [NFUNC-1:0]   r_en;
  logic [NFUNC-1:0]   w_enNext;
  logic [NFUNC-1:0]   w_decode;
  logic [WIDTH-1:0]   r_ans;
  logic [WIDTH-1:0]   w_ansNext;
  logic               r_zero;
  logic               w_zeroNext;
  logic               r_valid;
  logic               w_validNext;
  logic               r_fault;
  logic               w_faultNext;
  logic               w_idleReady;

  // Opcode decode. An opcode at or beyond NFUNC matches no unit and leaves
  // the enable vector all zero, so the bus is expected to read back zero.
  always_comb begin
    w_decode = '0;
    for (int i = 0; i < NFUNC; i++) begin
      w_decode[i] = (int'(req_op) == i);
    end
  end

  // Next-state and next-register logic. Everything holds by default; each
  // state only touches what it changes. The settle counter is loaded on
  // acceptance and the bus is captured on the edge where it already reads
  // zero, which keeps the enable asserted for exactly SETTLE cycles.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_aNext     = r_a;
    w_bNext     = r_b;
    w_enNext    = r_en;
    w_ansNext   = r_ans;
    w_zeroNext  = r_zero;
    w_validNext = r_valid;
    w_idleReady = 1'b0;
    case (r_state)
      IDLE: begin
        w_idleReady = 1'b1;
        w_enNext    = '0;
        if (req_valid) begin
          w_aNext     = req_a;
          w_bNext     = req_b;
          w_enNext    = w_decode;
          w_cntNext   = CNT_LOAD;
          w_stateNext = DRIVE;
        end
      end
      DRIVE: begin
        if (r_cnt == 2'd0) begin
          w_ansNext   = unit_ans;
          w_zeroNext  = (unit_ans == '0);
          w_enNext    = '0;
          w_validNext = 1'b1;
          w_stateNext = RESP;
        end else begin
          w_cntNext = r_cnt - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_validNext = 1'b0;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Bus fault: any non-zero value on the result bus while no unit is enabled
  // latches the fault until reset. It never influences sequencing.
  always_comb begin
    w_faultNext = r_fault | ((r_en == '0) && (unit_ans != '0));
  end

  // State and datapath registers. Reset discards any in-flight operation,
  // including a pending response, without a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_en    <= '0;
      r_ans   <= '0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_a     <= w_aNext;
      r_b     <= w_bNext;
      r_en    <= w_enNext;
      r_ans   <= w_ansNext;
      r_zero  <= w_zeroNext;
      r_valid <= w_validNext;
      r_fault <= w_faultNext;
    end
  end

  // Ready is held low during reset so nothing is accepted on a reset edge.
  assign req_ready = w_idleReady & ~rst;
  assign a         = r_a;
  assign b         = r_b;
  assign en        = r_en;
  assign rsp_valid = r_valid;
  assign rsp_ans   = r_ans;
  assign rsp_zero  = r_zero;
  assign fault     = r_fault;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer. Two instances share clock and reset:
// one with SETTLE=1 and one with SETTLE=3. Each has a behavioural model of the
// enable-gated function units driving its result bus (unit 0 AND, unit 9 XNOR,
// unit 15 OR, all others XOR), plus an override used to inject a bad bus value.

module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        reqValid1, reqReady1, rspValid1, rspReady1, rspZero1, fault1;
  logic [3:0]  reqOp1, reqA1, reqB1, a1, b1, unitAns1, rspAns1;
  logic [15:0] en1;
  logic        force1;
  logic [3:0]  forceVal1;

  logic        reqValid3, reqReady3, rspValid3, rspReady3, rspZero3, fault3;
  logic [3:0]  reqOp3, reqA3, reqB3, a3, b3, unitAns3, rspAns3;
  logic [15:0] en3;
  logic        force3;
  logic [3:0]  forceVal3;

  int nCompared   = 0;
  int nMismatched = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Function-unit model: one function per unit index.
  function automatic logic [3:0] unitFn(input int idx, input logic [3:0] x, input logic [3:0] y);
    case (idx)
      0:       return x & y;
      9:       return ~(x ^ y);
      15:      return x | y;
      default: return x ^ y;
    endcase
  endfunction

  // Wired-OR bus: every unit gates its result with its own enable.
  function automatic logic [3:0] modelBus(input logic [15:0] e, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = r | unitFn(i, x, y);
    end
    return r;
  endfunction

  assign unitAns1 = force1 ? forceVal1 : modelBus(en1, a1, b1);
  assign unitAns3 = force3 ? forceVal3 : modelBus(en3, a3, b3);

  alu_op_sequencer #(.WIDTH(4), .NFUNC(16), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid1), .req_ready(reqReady1),
    .req_op(reqOp1), .req_a(reqA1), .req_b(reqB1),
    .a(a1), .b(b1), .en(en1), .unit_ans(unitAns1),
    .rsp_valid(rspValid1), .rsp_ready(rspReady1),
    .rsp_ans(rspAns1), .rsp_zero(rspZero1), .fault(fault1)
  );

  alu_op_sequencer #(.WIDTH(4), .NFUNC(16), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid3), .req_ready(reqReady3),
    .req_op(reqOp3), .req_a(reqA3), .req_b(reqB3),
    .a(a3), .b(b3), .en(en3), .unit_ans(unitAns3),
    .rsp_valid(rspValid3), .rsp_ready(rspReady3),
    .rsp_ans(rspAns3), .rsp_zero(rspZero3), .fault(fault3)
  );

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Present a request on the SETTLE=1 instance.
  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    reqOp1    = op;
    reqA1     = x;
    reqB1     = y;
    reqValid1 = 1'b1;
  endtask

  // Present a request on the SETTLE=3 instance.
  task automatic applyStimulus3(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
    reqOp3    = op;
    reqA3     = x;
    reqB3     = y;
    reqValid3 = 1'b1;
  endtask

  logic [3:0] opList  [3] = '{4'd9, 4'd0, 4'd15};
  logic [3:0] aList   [3] = '{4'b1010, 4'hF, 4'b0100};
  logic [3:0] bList   [3] = '{4'b1100, 4'h3, 4'b0001};
  logic [3:0] ansList [3] = '{4'b1001, 4'h3, 4'b0101};

  initial begin
    int idx;
    int cyc;
    int lastCyc;
    logic [15:0] oneHot;

    reqValid1 = 1'b0; reqOp1 = '0; reqA1 = '0; reqB1 = '0; rspReady1 = 1'b0;
    force1 = 1'b0; forceVal1 = '0;
    reqValid3 = 1'b0; reqOp3 = '0; reqA3 = '0; reqB3 = '0; rspReady3 = 1'b0;
    force3 = 1'b0; forceVal3 = '0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_en",        32'(en1),       32'h0);
    checkOutput("rst_a",         32'(a1),        32'h0);
    checkOutput("rst_rsp_valid", 32'(rspValid1), 32'h0);
    checkOutput("rst_rsp_ans",   32'(rspAns1),   32'h0);
    checkOutput("rst_rsp_zero",  32'(rspZero1),  32'h0);
    checkOutput("rst_fault",     32'(fault1),    32'h0);
    checkOutput("rst_req_ready", 32'(reqReady1), 32'h0);
    checkOutput("rst_en3",       32'(en3),       32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(reqReady1), 32'h1);

    // Basic XNOR: 1010 xnor 1100 = 1001
    @(negedge clk);
    rspReady1 = 1'b1;
    applyStimulus(4'd9, 4'b1010, 4'b1100);
    @(negedge clk);
    checkOutput("xnor_en",        32'(en1),       32'h0200);
    checkOutput("xnor_a",         32'(a1),        32'hA);
    checkOutput("xnor_b",         32'(b1),        32'hC);
    checkOutput("xnor_req_ready", 32'(reqReady1), 32'h0);
    checkOutput("xnor_early_vld", 32'(rspValid1), 32'h0);
    reqValid1 = 1'b0;
    @(negedge clk);
    checkOutput("xnor_rsp_valid", 32'(rspValid1), 32'h1);
    checkOutput("xnor_ans",       32'(rspAns1),   32'h9);
    checkOutput("xnor_zero",      32'(rspZero1),  32'h0);
    checkOutput("xnor_en_off",    32'(en1),       32'h0);
    @(negedge clk);
    checkOutput("xnor_vld_drop",  32'(rspValid1), 32'h0);
    checkOutput("xnor_ready_back",32'(reqReady1), 32'h1);

    // Zero result under backpressure: 0101 xnor 1010 = 0000
    rspReady1 = 1'b0;
    applyStimulus(4'd9, 4'b0101, 4'b1010);
    @(negedge clk);
    reqValid1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 32'(rspValid1), 32'h1);
      checkOutput("bp_ans",   32'(rspAns1),   32'h0);
      checkOutput("bp_zero",  32'(rspZero1),  32'h1);
      checkOutput("bp_ready", 32'(reqReady1), 32'h0);
      reqOp1    = 4'd0;
      reqValid1 = (i % 2 == 0);
      @(negedge clk);
    end
    reqValid1 = 1'b0;
    rspReady1 = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_vld", 32'(rspValid1), 32'h0);
    checkOutput("bp_no_accept",   32'(en1),       32'h0);
    @(negedge clk);
    checkOutput("bp_still_idle",  32'(en1),       32'h0);

    // Back-to-back with req_valid held high
    idx     = 0;
    cyc     = 0;
    lastCyc = 0;
    applyStimulus(opList[0], aList[0], bList[0]);
    for (int c = 0; c < 20 && idx < 3; c++) begin
      @(negedge clk);
      cyc++;
      if (en1 != 16'h0) begin
        oneHot = 16'h1 << opList[idx];
        checkOutput("b2b_en", 32'(en1), 32'(oneHot));
      end
      if (rspValid1) begin
        checkOutput("b2b_ans", 32'(rspAns1), 32'(ansList[idx]));
        if (idx > 0) checkOutput("b2b_spacing", 32'(cyc - lastCyc), 32'd3);
        lastCyc = cyc;
        idx++;
        if (idx < 3) applyStimulus(opList[idx], aList[idx], bList[idx]);
        else reqValid1 = 1'b0;
      end
    end
    checkOutput("b2b_count", 32'(idx), 32'd3);

    // Bus fault while idle, sticky across a good operation
    @(negedge clk);
    force1    = 1'b1;
    forceVal1 = 4'h4;
    @(negedge clk);
    checkOutput("fault_set", 32'(fault1), 32'h1);
    force1 = 1'b0;
    applyStimulus(4'd0, 4'hF, 4'h3);
    @(negedge clk);
    reqValid1 = 1'b0;
    checkOutput("fault_op_en", 32'(en1), 32'h0001);
    @(negedge clk);
    checkOutput("fault_op_ans",   32'(rspAns1), 32'h3);
    checkOutput("fault_sticky_1", 32'(fault1),  32'h1);
    @(negedge clk);
    checkOutput("fault_sticky_2", 32'(fault1),  32'h1);

    // Reset during DRIVE
    applyStimulus(4'd9, 4'b1010, 4'b1100);
    @(negedge clk);
    checkOutput("mid_drive_en", 32'(en1), 32'h0200);
    reqValid1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_drive_en",    32'(en1),       32'h0);
    checkOutput("rst_drive_a",     32'(a1),        32'h0);
    checkOutput("rst_drive_vld",   32'(rspValid1), 32'h0);
    checkOutput("rst_drive_fault", 32'(fault1),    32'h0);
    checkOutput("rst_drive_ready", 32'(reqReady1), 32'h0);
    rst = 1'b0;

    // Reset during RESP: 0100 | 0001 = 0101 is discarded
    rspReady1 = 1'b0;
    applyStimulus(4'd15, 4'b0100, 4'b0001);
    @(negedge clk);
    reqValid1 = 1'b0;
    @(negedge clk);
    checkOutput("mid_resp_vld", 32'(rspValid1), 32'h1);
    checkOutput("mid_resp_ans", 32'(rspAns1),   32'h5);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_resp_vld",  32'(rspValid1), 32'h0);
    checkOutput("rst_resp_ans",  32'(rspAns1),   32'h0);
    checkOutput("rst_resp_zero", 32'(rspZero1),  32'h0);
    rst = 1'b0;

    // First request after reset completes normally
    rspReady1 = 1'b1;
    applyStimulus(4'd9, 4'b1010, 4'b1100);
    @(negedge clk);
    reqValid1 = 1'b0;
    checkOutput("after_rst_vld0", 32'(rspValid1), 32'h0);
    @(negedge clk);
    checkOutput("after_rst_vld1", 32'(rspValid1), 32'h1);
    checkOutput("after_rst_ans",  32'(rspAns1),   32'h9);

    // SETTLE=3: enable held three cycles, early bus glitch ignored
    @(negedge clk);
    rspReady3 = 1'b1;
    applyStimulus3(4'd0, 4'hF, 4'h3);
    @(negedge clk);
    reqValid3 = 1'b0;
    checkOutput("settle_en_1", 32'(en3), 32'h0001);
    force3    = 1'b1;
    forceVal3 = 4'hC;
    @(negedge clk);
    checkOutput("settle_en_2",  32'(en3),       32'h0001);
    checkOutput("settle_vld_2", 32'(rspValid3), 32'h0);
    @(negedge clk);
    checkOutput("settle_en_3",  32'(en3),       32'h0001);
    checkOutput("settle_vld_3", 32'(rspValid3), 32'h0);
    force3 = 1'b0;
    @(negedge clk);
    checkOutput("settle_vld",   32'(rspValid3), 32'h1);
    checkOutput("settle_ans",   32'(rspAns3),   32'h3);
    checkOutput("settle_zero",  32'(rspZero3),  32'h0);
    checkOutput("settle_en_off",32'(en3),       32'h0);
    @(negedge clk);
    checkOutput("settle_done",  32'(rspValid3), 32'h0);
    checkOutput("settle_ready", 32'(reqReady3), 32'h1);
    checkOutput("settle_fault", 32'(fault3),    32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
